// File: rtl/abb_pkg.sv
// Shared constants for the 2-bit symbol link transmitter: FSM encoding and
// the fixed header/idle symbols.
package abb_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    H0   = 3'd1,
    H1   = 3'd2,
    H2   = 3'd3,
    PAY  = 3'd4
  } state_e;

  localparam logic [1:0] SYM_IDLE = 2'b11;
  localparam logic [1:0] HDR0     = 2'b00;
  localparam logic [1:0] HDR1     = 2'b01;
  localparam logic [1:0] HDR2     = 2'b01;

endpackage

// File: rtl/Registro.sv
// Generic W-bit register with enable and asynchronous active-high clear.
module Registro #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state is always written with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sym_shreg.sv
// Payload shift register: parallel load of a word, then shift left by one
// 2-bit symbol per enabled cycle, exposing the current most-significant pair.
module sym_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data_in,
  output logic [1:0]        msb_pair
);

  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] d;
  logic              en;

  assign en = load | shift;

  // A one-symbol payload has nothing to shift in behind it.
  generate
    if (DATA_W > 2) begin : g_wide
      assign d = load ? data_in : {q[DATA_W-3:0], 2'b00};
    end else begin : g_pair
      assign d = load ? data_in : '0;
    end
  endgenerate

  Registro #(.W(DATA_W)) u_reg (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q)
  );

  assign msb_pair = q[DATA_W-1 -: 2];

endmodule

// File: rtl/abb_tx.sv
// Frame transmitter: accepts a word on valid/ready and sends a 3-symbol
// header followed by the payload as 2-bit symbols, MSB pair first.
module abb_tx
  import abb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [1:0]        sym_out,
  output logic              sym_valid,
  output logic              frame_done
);

  localparam int P     = DATA_W / 2;
  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       msb_pair;
  logic             load;
  logic             shift;

  assign load  = (state == IDLE) && valid_in;
  assign shift = (state == PAY);

  sym_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .data_in  (data_in),
    .msb_pair (msb_pair)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          state <= H0;
          cnt   <= '0;
        end
        H0:   state <= H1;
        H1:   state <= H2;
        H2:   state <= PAY;
        // The counter holds at its last value until the next acceptance clears it.
        PAY:  if (cnt == CNT_LAST) state <= IDLE;
              else                 cnt   <= cnt + CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // value held, which would otherwise infer a latch.
  always_comb begin
    ready_out  = 1'b0;
    sym_out    = SYM_IDLE;
    sym_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: ready_out = 1'b1;
      H0: begin
        sym_out   = HDR0;
        sym_valid = 1'b1;
      end
      H1: begin
        sym_out   = HDR1;
        sym_valid = 1'b1;
      end
      H2: begin
        sym_out   = HDR2;
        sym_valid = 1'b1;
      end
      PAY: begin
        sym_out    = msb_pair;
        sym_valid  = 1'b1;
        frame_done = (cnt == CNT_LAST);
      end
      default: ;
    endcase
  end

endmodule
